// File: rtl/sme_job_sequencer.sv
// sme_job_sequencer: buffers one host job (optional string + pattern), replays it
// to the string match engine as back-to-back strobe bursts, then returns one
// result beat carrying the engine's match/index and the job's status flags.
//
// state    | meaning
// ---------+---------------------------------------------------------------
// IDLE     | waiting for the first character of a job
// LOAD_STR | buffering string characters
// LOAD_PAT | buffering pattern characters
// SEND_STR | isstring burst, one buffered string character per cycle
// SEND_PAT | ispattern burst, one buffered pattern character per cycle
// WAIT     | strobes idle, waiting for out_valid or the timeout
// RESULT   | result beat offered to the host until res_ready
module sme_job_sequencer #(
    parameter int STR_MAX = 32,
    parameter int PAT_MAX = 8,
    parameter int TIMEOUT = 64
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic       in_kind,
    input  logic       in_last,
    input  logic [7:0] in_data,
    output logic       isstring,
    output logic       ispattern,
    output logic [7:0] chardata,
    input  logic       out_valid,
    input  logic       match,
    input  logic [4:0] match_index,
    output logic       res_valid,
    input  logic       res_ready,
    output logic       res_match,
    output logic [4:0] res_index,
    output logic [2:0] res_flags
);
    localparam int             WW        = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [5:0]     STR_MAX_L = 6'(STR_MAX);
    localparam logic [3:0]     PAT_MAX_L = 4'(PAT_MAX);
    localparam logic [WW-1:0]  WAIT_LAST = WW'(TIMEOUT - 1);
    localparam logic [WW-1:0]  WAIT_ONE  = WW'(1);

    typedef enum logic [2:0] {
        IDLE, LOAD_STR, LOAD_PAT, SEND_STR, SEND_PAT, WAIT, RESULT
    } state_t;

    state_t        state, state_d;
    logic [7:0]    str_buf [32];
    logic [7:0]    pat_buf [8];
    logic [5:0]    str_len, str_len_d;
    logic [3:0]    pat_len, pat_len_d;
    logic [5:0]    k, k_d;
    logic [WW-1:0] wait_cnt;
    logic          str_loaded, new_str, ovf, nostr, tmo;
    logic          xfer, str_wr, pat_wr, ovf_set, str_load_done;
    logic [4:0]    str_wr_idx;
    logic [2:0]    pat_wr_idx;
    logic [7:0]    chardata_d;

    assign in_ready  = (state == IDLE) || (state == LOAD_STR) || (state == LOAD_PAT);
    assign xfer      = in_valid && in_ready;
    assign res_valid = (state == RESULT);
    assign res_flags = res_valid ? {tmo, ovf, nostr} : 3'b000;

    // Next-state, buffer write control and burst pointer.
    always_comb begin
        state_d       = state;
        k_d           = k;
        str_len_d     = str_len;
        pat_len_d     = pat_len;
        str_wr        = 1'b0;
        pat_wr        = 1'b0;
        ovf_set       = 1'b0;
        str_load_done = 1'b0;
        str_wr_idx    = str_len[4:0];
        pat_wr_idx    = pat_len[2:0];
        case (state)
            IDLE: begin
                if (xfer) begin
                    k_d = 6'd0;
                    if (!in_kind) begin
                        str_wr     = 1'b1;
                        str_wr_idx = 5'd0;
                        str_len_d  = 6'd1;
                        state_d    = in_last ? LOAD_PAT : LOAD_STR;
                    end else begin
                        pat_wr     = 1'b1;
                        pat_wr_idx = 3'd0;
                        pat_len_d  = 4'd1;
                        state_d    = in_last ? SEND_PAT : LOAD_PAT;
                    end
                end
            end
            LOAD_STR: begin
                if (xfer) begin
                    k_d = 6'd0;
                    if (!in_kind) begin
                        if (str_len < STR_MAX_L) begin
                            str_wr    = 1'b1;
                            str_len_d = str_len + 6'd1;
                        end else begin
                            ovf_set = 1'b1;
                        end
                        if (in_last) state_d = LOAD_PAT;
                    end else begin
                        // A pattern beat ends the string and opens the pattern.
                        pat_wr    = 1'b1;
                        pat_len_d = 4'd1;
                        state_d   = in_last ? SEND_STR : LOAD_PAT;
                    end
                end
            end
            LOAD_PAT: begin
                if (xfer) begin
                    if (in_kind && (pat_len < PAT_MAX_L)) begin
                        pat_wr    = 1'b1;
                        pat_len_d = pat_len + 4'd1;
                    end else begin
                        ovf_set = 1'b1;
                    end
                    if (in_last) begin
                        k_d = 6'd0;
                        if (new_str)                state_d = SEND_STR;
                        else if (pat_len_d != 4'd0) state_d = SEND_PAT;
                        else                        state_d = WAIT;
                    end
                end
            end
            SEND_STR: begin
                if (k == str_len - 6'd1) begin
                    str_load_done = 1'b1;
                    k_d           = 6'd0;
                    state_d       = (pat_len != 4'd0) ? SEND_PAT : WAIT;
                end else begin
                    k_d = k + 6'd1;
                end
            end
            SEND_PAT: begin
                if (k == {2'b00, pat_len} - 6'd1) begin
                    k_d     = 6'd0;
                    state_d = WAIT;
                end else begin
                    k_d = k + 6'd1;
                end
            end
            WAIT: begin
                if (out_valid || (wait_cnt == WAIT_LAST)) state_d = RESULT;
            end
            RESULT: begin
                if (res_ready) begin
                    pat_len_d = 4'd0;
                    state_d   = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Character for the next strobe cycle; a one-character pattern-only job
    // starts its burst on the same edge that writes pat_buf[0], hence the bypass.
    always_comb begin
        chardata_d = 8'h00;
        if (state_d == SEND_STR) begin
            chardata_d = str_buf[k_d[4:0]];
        end else if (state_d == SEND_PAT) begin
            chardata_d = (pat_wr && (pat_wr_idx == k_d[2:0])) ? in_data : pat_buf[k_d[2:0]];
        end
    end

    // Character buffers; contents are only meaningful below the lengths.
    always_ff @(posedge clk) begin
        if (str_wr) str_buf[str_wr_idx] <= in_data;
        if (pat_wr) pat_buf[pat_wr_idx] <= in_data;
    end

    // State, lengths, flags, registered SME strobes and captured result.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            str_len    <= 6'd0;
            pat_len    <= 4'd0;
            k          <= 6'd0;
            wait_cnt   <= '0;
            str_loaded <= 1'b0;
            new_str    <= 1'b0;
            ovf        <= 1'b0;
            nostr      <= 1'b0;
            tmo        <= 1'b0;
            res_match  <= 1'b0;
            res_index  <= 5'd0;
            isstring   <= 1'b0;
            ispattern  <= 1'b0;
            chardata   <= 8'h00;
        end else begin
            state     <= state_d;
            str_len   <= str_len_d;
            pat_len   <= pat_len_d;
            k         <= k_d;
            isstring  <= (state_d == SEND_STR);
            ispattern <= (state_d == SEND_PAT);
            chardata  <= chardata_d;
            wait_cnt  <= (state == WAIT) ? wait_cnt + WAIT_ONE : '0;
            if (ovf_set)       ovf        <= 1'b1;
            if (str_load_done) str_loaded <= 1'b1;
            if ((state == IDLE) && xfer) begin
                new_str <= !in_kind;
                nostr   <= in_kind && !str_loaded;
            end
            if ((state == WAIT) && (state_d == RESULT)) begin
                res_match <= out_valid && match;
                res_index <= out_valid ? match_index : 5'd0;
                tmo       <= !out_valid;
            end
            if ((state == RESULT) && res_ready) begin
                ovf       <= 1'b0;
                nostr     <= 1'b0;
                tmo       <= 1'b0;
                res_match <= 1'b0;
                res_index <= 5'd0;
            end
        end
    end
endmodule

// File: tb/tb_sme_job_sequencer.sv
// Directed bench for sme_job_sequencer: a scoreboard queue holds the expected
// strobe stream per job, a monitor pops it on every strobe, and the main
// sequence plays host and SME and checks result beats and timing.
module tb_sme_job_sequencer;
    localparam int STR_MAX = 32;
    localparam int PAT_MAX = 8;
    localparam int TIMEOUT = 64;

    logic       clk = 1'b0;
    logic       rst;
    logic       in_valid, in_ready, in_kind, in_last;
    logic [7:0] in_data;
    logic       isstring, ispattern;
    logic [7:0] chardata;
    logic       out_valid, match;
    logic [4:0] match_index;
    logic       res_valid, res_ready, res_match;
    logic [4:0] res_index;
    logic [2:0] res_flags;

    sme_job_sequencer #(.STR_MAX(STR_MAX), .PAT_MAX(PAT_MAX), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_kind(in_kind),
        .in_last(in_last), .in_data(in_data),
        .isstring(isstring), .ispattern(ispattern), .chardata(chardata),
        .out_valid(out_valid), .match(match), .match_index(match_index),
        .res_valid(res_valid), .res_ready(res_ready), .res_match(res_match),
        .res_index(res_index), .res_flags(res_flags)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic       kind;
        logic [7:0] d;
    } exp_t;

    exp_t       exp_q[$];
    int         checks = 0;
    int         failures = 0;
    int         cyc = 0;
    int         n_str, n_pat, first_cyc, last_cyc, last_xfer, rv_cyc;
    logic [7:0] tx [64];
    int         tx_len;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Strobe monitor: every strobe must match the head of the scoreboard.
    always @(negedge clk) begin
        exp_t e;
        if (!rst) begin
            if (isstring || ispattern) begin
                chk("strobe_exclusive", {31'd0, isstring & ispattern}, 32'd0);
                if ((n_str + n_pat) == 0) first_cyc = cyc;
                last_cyc = cyc;
                if (isstring) n_str++;
                if (ispattern) n_pat++;
                if (exp_q.size() == 0) begin
                    chk("strobe_unexpected", {30'd0, isstring, ispattern}, 32'd0);
                end else begin
                    e = exp_q.pop_front();
                    chk("strobe_kind", {30'd0, isstring, ispattern}, e.kind ? 32'd1 : 32'd2);
                    chk("strobe_char", {24'd0, chardata}, {24'd0, e.d});
                end
            end else begin
                chk("chardata_idle", {24'd0, chardata}, 32'd0);
            end
        end
    end

    task automatic load_tx(input string s);
        tx_len = s.len();
        for (int i = 0; i < tx_len; i++) tx[i] = s[i];
    endtask

    // Called at a negedge; returns at the negedge after the transfer.
    task automatic send_beat(input logic kind, input logic last, input logic [7:0] d);
        int n = 0;
        in_valid = 1'b1; in_kind = kind; in_last = last; in_data = d;
        while (!in_ready && n < 100) begin @(negedge clk); n++; end
        chk("in_ready_seen", {31'd0, in_ready}, 32'd1);
        last_xfer = cyc;
        @(negedge clk);
        in_valid = 1'b0; in_last = 1'b0;
    endtask

    task automatic send_seg(input logic kind, input int maxn);
        exp_t e;
        for (int i = 0; i < tx_len; i++) begin
            if (i < maxn) begin
                e.kind = kind; e.d = tx[i];
                exp_q.push_back(e);
            end
            send_beat(kind, (i == tx_len - 1), tx[i]);
        end
    endtask

    task automatic new_job();
        n_str = 0; n_pat = 0; first_cyc = -1; last_cyc = -1;
    endtask

    task automatic wait_strobes_done();
        int n = 0;
        while (exp_q.size() != 0 && n < 400) begin @(negedge clk); n++; end
        chk("burst_complete", exp_q.size(), 32'd0);
    endtask

    task automatic check_burst(input int s, input int p);
        chk("n_isstring", n_str, s);
        chk("n_ispattern", n_pat, p);
        chk("first_strobe_cycle", first_cyc, last_xfer + 1);
        chk("last_strobe_cycle", last_cyc, last_xfer + s + p);
    endtask

    task automatic sme_reply(input logic m, input logic [4:0] idx);
        @(negedge clk); @(negedge clk);
        out_valid = 1'b1; match = m; match_index = idx;
        @(negedge clk);
        out_valid = 1'b0; match = 1'b0; match_index = 5'd0;
    endtask

    task automatic get_result(input int pre, input int hold, input logic em,
                              input logic [4:0] ei, input logic [2:0] ef);
        int n = 0;
        if (pre != 0) res_ready = 1'b1;
        while (!res_valid && n < 300) begin @(negedge clk); n++; end
        chk("res_valid_seen", {31'd0, res_valid}, 32'd1);
        rv_cyc = cyc;
        for (int i = 0; i <= hold; i++) begin
            chk("res_match", {31'd0, res_match}, {31'd0, em});
            chk("res_index", {27'd0, res_index}, {27'd0, ei});
            chk("res_flags", {29'd0, res_flags}, {29'd0, ef});
            chk("in_ready_in_result", {31'd0, in_ready}, 32'd0);
            if (hold > 0) chk("res_valid_held", {31'd0, res_valid}, 32'd1);
            if (i < hold) @(negedge clk);
        end
        res_ready = 1'b1;
        @(negedge clk);
        res_ready = 1'b0;
        chk("res_valid_after_accept", {31'd0, res_valid}, 32'd0);
        chk("in_ready_after_accept", {31'd0, in_ready}, 32'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired observed=running expected=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; in_valid = 1'b0; in_kind = 1'b0; in_last = 1'b0; in_data = 8'h00;
        out_valid = 1'b0; match = 1'b0; match_index = 5'd0; res_ready = 1'b0;
        new_job();
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
        chk("rst_strobes", {30'd0, isstring, ispattern}, 32'd0);
        chk("rst_chardata", {24'd0, chardata}, 32'd0);
        chk("rst_res_valid", {31'd0, res_valid}, 32'd0);
        chk("rst_res", {23'd0, res_match, res_index, res_flags}, 32'd0);
        rst = 1'b0;
        @(negedge clk);

        // Job 1: full string plus pattern.
        new_job();
        load_tx("THIS IS A BOOK"); send_seg(1'b0, STR_MAX);
        load_tx("BOOK");           send_seg(1'b1, PAT_MAX);
        chk("in_ready_while_send", {31'd0, in_ready}, 32'd0);
        wait_strobes_done();
        check_burst(14, 4);
        sme_reply(1'b1, 5'd10);
        get_result(0, 0, 1'b1, 5'd10, 3'b000);

        // Job 2: pattern-only reuse; res_ready already high.
        new_job();
        load_tx("IS"); send_seg(1'b1, PAT_MAX);
        wait_strobes_done();
        check_burst(0, 2);
        sme_reply(1'b1, 5'd2);
        get_result(1, 0, 1'b1, 5'd2, 3'b000);

        // Job 3: stray out_valid in IDLE, then the engine never answers.
        out_valid = 1'b1; match = 1'b1; match_index = 5'd7;
        @(negedge clk);
        out_valid = 1'b0; match = 1'b0; match_index = 5'd0;
        chk("ignored_out_valid", {31'd0, res_valid}, 32'd0);
        new_job();
        load_tx("XYZ"); send_seg(1'b1, PAT_MAX);
        wait_strobes_done();
        check_burst(0, 3);
        get_result(0, 0, 1'b0, 5'd0, 3'b100);
        chk("timeout_cycle", rv_cyc, last_cyc + TIMEOUT + 1);

        // Job 4: string and pattern both overflow.
        new_job();
        tx_len = 40;
        for (int i = 0; i < 40; i++) tx[i] = 8'h41 + 8'(i % 26);
        send_seg(1'b0, STR_MAX);
        tx_len = 10;
        for (int i = 0; i < 10; i++) tx[i] = 8'h30 + 8'(i);
        send_seg(1'b1, PAT_MAX);
        wait_strobes_done();
        check_burst(32, 8);
        sme_reply(1'b0, 5'd0);
        get_result(0, 0, 1'b0, 5'd0, 3'b010);

        // Job 5: host stalls the result for five cycles.
        new_job();
        load_tx("OK"); send_seg(1'b1, PAT_MAX);
        wait_strobes_done();
        check_burst(0, 2);
        sme_reply(1'b0, 5'd5);
        get_result(0, 5, 1'b0, 5'd5, 3'b000);

        // Job 6: reset in the middle of the pattern burst.
        new_job();
        load_tx("ABCDEF"); send_seg(1'b1, PAT_MAX);
        begin
            int n = 0;
            while (n_pat < 2 && n < 100) begin @(negedge clk); n++; end
            chk("mid_burst_reached", {31'd0, ispattern}, 32'd1);
        end
        rst = 1'b1;
        @(posedge clk);
        exp_q.delete();
        @(negedge clk);
        chk("midrst_strobes", {30'd0, isstring, ispattern}, 32'd0);
        chk("midrst_chardata", {24'd0, chardata}, 32'd0);
        chk("midrst_in_ready", {31'd0, in_ready}, 32'd1);
        chk("midrst_res_valid", {31'd0, res_valid}, 32'd0);
        rst = 1'b0;
        @(negedge clk);

        // Job 7: pattern-only right after reset -> no_string.
        new_job();
        load_tx("IS"); send_seg(1'b1, PAT_MAX);
        wait_strobes_done();
        check_burst(0, 2);
        sme_reply(1'b1, 5'd3);
        get_result(0, 0, 1'b1, 5'd3, 3'b001);

        repeat (3) @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
